// File: rtl/line_burst_adaptor.sv
// Line-to-burst adaptor: turns each 256-bit line read/write into a burst of BEAT_W-bit memory beats.
// Optional watchdog enabled by defining LINE_BURST_TIMEOUT_EN (adds the timeout_err port).
module line_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_address,
  output logic [LINE_W-1:0] line_rdata,
  input  logic [LINE_W-1:0] line_wdata,
  input  logic              line_read,
  input  logic              line_write,
  output logic              line_resp,
  output logic [ADDR_W-1:0] burst_address,
  input  logic [BEAT_W-1:0] burst_rdata,
  output logic [BEAT_W-1:0] burst_wdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp
`ifdef LINE_BURST_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt;
  logic [LINE_W-1:0]  line_buf;
  logic               tmo_hit;
  logic               last_beat;

  assign last_beat = burst_resp && (beat_cnt == LAST);

`ifdef LINE_BURST_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wdog_q;

  assign tmo_hit = ((state_q == RD) || (state_q == WR)) && !burst_resp &&
                   (wdog_q == WD_W'(TMO_CYC - 1));

  // Counts consecutive busy cycles with no beat; any beat restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (((state_q == RD) || (state_q == WR)) && !burst_resp && !tmo_hit)
        wdog_q <= wdog_q + 1'b1;
      else
        wdog_q <= '0;
      if (tmo_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (line_read)       state_d = RD;
        else if (line_write) state_d = WR;
      end
      RD, WR: begin
        if (last_beat || tmo_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: line_rdata is reset like any other visible output; it is a plain register, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt      <= '0;
      burst_address <= '0;
      line_buf      <= '0;
      line_rdata    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_read || line_write) begin
            burst_address <= {line_address[ADDR_W-1:OFF_W], OFF_W'(0)};
            beat_cnt      <= '0;
            if (!line_read) line_buf <= line_wdata;
          end
        end
        RD: begin
          if (burst_resp) begin
            for (int b = 0; b < BEATS; b++)
              if (beat_cnt == CNT_W'(b)) line_rdata[b*BEAT_W +: BEAT_W] <= burst_rdata;
            beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
          end else if (tmo_hit) begin
            beat_cnt <= '0;
          end
        end
        WR: begin
          if (burst_resp)   beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
          else if (tmo_hit) beat_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign burst_read  = (state_q == RD);
  assign burst_write = (state_q == WR);
  assign line_resp   = (state_q == DONE);

  always_comb begin
    burst_wdata = '0;
    for (int b = 0; b < BEATS; b++)
      if (burst_write && (beat_cnt == CNT_W'(b))) burst_wdata = line_buf[b*BEAT_W +: BEAT_W];
  end

endmodule
